// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int unsigned CLK_FREQ_HZ          = 50_000_000;
    localparam int unsigned BAUD                 = 115200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks every CLKS_PER_BIT cycles while enabled, realigned by clear.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clear && (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start, LSB-first data, stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);
    localparam logic            LastStop = 1'(STOP_BITS - 1);

    uart_state_t          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IdxW-1:0]      bit_idx_q;
    logic                 stop_idx_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 handshake;
    logic                 tick;

    assign tx_ready  = (state_q == IDLE);
    assign busy      = !tx_ready;
    assign tx        = tx_q;
    assign tx_done   = done_q;
    assign handshake = tx_valid && tx_ready;

    // Clearing on acceptance aligns every bit boundary to the handshake edge.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(handshake),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q   <= tx_data;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == LastIdx) begin
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                            state_q    <= STOP;
                        end else begin
                            // Next bit is shift_q[1]; the register shifts in the same edge.
                            tx_q      <= shift_q[1];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_idx_q == LastStop) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 4-cycle bit period with one stop bit, plus 434-cycle with two.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx, busy, tx_done;
    logic       tx_ready2, tx2, busy2, tx_done2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(4),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    uart_tx #(
        .CLKS_PER_BIT(434),
        .DATA_BITS   (8),
        .STOP_BITS   (2)
    ) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data2),
        .tx_valid(tx_valid2),
        .tx_ready(tx_ready2),
        .tx      (tx2),
        .busy    (busy2),
        .tx_done (tx_done2)
    );

    // Expected line level in frame cycle c (1-based from the cycle after acceptance).
    function automatic logic exp_tx(input logic [7:0] b, input int c, input int cpb);
        int bi;
        bi = (c - 1) / cpb;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx_%0d", i), tx, 1);
            check($sformatf("idle_ready_%0d", i), tx_ready, 1);
            check($sformatf("idle_busy_%0d", i), busy, 0);
            check($sformatf("idle_done_%0d", i), tx_done, 0);
        end
    endtask

    // Called at a negedge where the DUT is idle; offers byte b in this cycle (cycle 0).
    task automatic frame(input logic [7:0] b, input bit keep, input bit chaos);
        tx_data  = b;
        tx_valid = 1'b1;
        check($sformatf("hs_ready_%02h", b), tx_ready, 1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!keep) tx_valid = 1'b0;
            if (chaos) begin
                tx_data  = 8'h3C;
                tx_valid = c[0];
            end
            check($sformatf("tx_%02h_c%0d", b, c), tx, exp_tx(b, c, 4));
            check($sformatf("ready_%02h_c%0d", b, c), tx_ready, 0);
            check($sformatf("busy_%02h_c%0d", b, c), busy, 1);
            check($sformatf("done_%02h_c%0d", b, c), tx_done, 0);
        end
        @(negedge clk);
        check($sformatf("tx_%02h_c41", b), tx, 1);
        check($sformatf("ready_%02h_c41", b), tx_ready, 1);
        check($sformatf("busy_%02h_c41", b), busy, 0);
        check($sformatf("done_%02h_c41", b), tx_done, 1);
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'hA5;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;

        // Reset with tx_valid high: rst wins, nothing starts.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_tx_%0d", i), tx, 1);
            check($sformatf("rst_ready_%0d", i), tx_ready, 1);
            check($sformatf("rst_busy_%0d", i), busy, 0);
            check($sformatf("rst_done_%0d", i), tx_done, 0);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        idle(1);

        frame(8'hA5, 1'b0, 1'b0);
        idle(2);

        // Back-to-back with tx_valid held: second acceptance in the tx_done cycle.
        frame(8'h00, 1'b1, 1'b0);
        frame(8'hFF, 1'b0, 1'b0);
        idle(2);

        // Input churn while busy must not disturb the frame or start another.
        frame(8'h81, 1'b0, 1'b1);
        idle(3);

        // Abort mid-frame.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        check("abort_hs_ready", tx_ready, 1);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            check($sformatf("abort_tx_c%0d", c), tx, exp_tx(8'hFF, c, 4));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_c16", tx, 1);
        check("abort_ready_c16", tx_ready, 1);
        check("abort_done_c16", tx_done, 0);
        idle(45);
        frame(8'h55, 1'b0, 1'b0);
        idle(1);

        // Two stop bits at the real baud divisor.
        tx_data2  = 8'h01;
        tx_valid2 = 1'b1;
        check("s2_hs_ready", tx_ready2, 1);
        for (int c = 1; c <= 4775; c++) begin
            @(negedge clk);
            tx_valid2 = 1'b0;
            check($sformatf("s2_tx_c%0d", c), tx2, exp_tx(8'h01, c, 434));
            check($sformatf("s2_done_c%0d", c), tx_done2, (c == 4775) ? 1 : 0);
            check($sformatf("s2_busy_c%0d", c), busy2, (c < 4775) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
